// File: rtl/pixel_proc_node.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : pixel_proc_node
// Purpose  : NoC processing element. It accepts one flit per packet, applies
//            a run-time selected per-pixel operation to every pixel lane, and
//            rewrites the header so the result goes to a fixed collector node.
//            Results are queued in an internal first-word-fall-through FIFO
//            that applies real backpressure to the router.
//
// Flit layout (LSB first):
//   [X_SIZE-1:0]          destination X   (rewritten to DST_X)
//   [+Y_SIZE]             destination Y   (rewritten to DST_Y)
//   [+PCK_NUM]            packet number   (copied unchanged)
//   [+ITER*PIX_W]         pixel lanes, lane 0 lowest
//   [TOTAL_WIDTH-1:...]   spare, driven 0 on output
//
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   i_data        inbound flit
//   i_valid       inbound flit valid
//   o_ready       node can take a flit this cycle (registered state only)
//   o_data        outbound flit = FIFO head (0 while o_valid=0)
//   o_valid       outbound flit valid
//   i_ready       downstream accepts o_data this cycle
//   i_mode        0=invert, 1=pass, 2=threshold, 3=saturating add
//   i_param       threshold / addend, sampled with each accepted flit
//   o_rx_count    flits accepted  (statistics build only, else 0)
//   o_tx_count    flits delivered (statistics build only, else 0)
//
// Build option: define PIXEL_NODE_STATS_EN to build the rx/tx counters.
// FIFO_DEPTH must be a power of two and at least 2.
//
// Revision : 1.0 - initial parametrised release
// ============================================================================
module pixel_proc_node #(
    parameter int X_SIZE      = 4,
    parameter int Y_SIZE      = 4,
    parameter int PCK_NUM     = 8,
    parameter int PIX_W       = 8,
    parameter int ITER        = 4,
    parameter int TOTAL_WIDTH = 48,
    parameter int FIFO_DEPTH  = 8,
    parameter int DST_X       = 0,
    parameter int DST_Y       = 0
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [TOTAL_WIDTH-1:0] i_data,
    input  logic                   i_valid,
    output logic                   o_ready,
    output logic [TOTAL_WIDTH-1:0] o_data,
    output logic                   o_valid,
    input  logic                   i_ready,
    input  logic [1:0]             i_mode,
    input  logic [PIX_W-1:0]       i_param,
    output logic [31:0]            o_rx_count,
    output logic [31:0]            o_tx_count
);

    // ------------------------------------------------------------------------
    // Field positions and FIFO sizing
    // ------------------------------------------------------------------------
    localparam int c_HDR_W   = X_SIZE + Y_SIZE;
    localparam int c_PCK_LSB = c_HDR_W;
    localparam int c_PIX_LSB = c_HDR_W + PCK_NUM;
    localparam int c_PIX_END = c_PIX_LSB + ITER * PIX_W;
    localparam int c_PTR_W   = $clog2(FIFO_DEPTH);
    localparam int c_CNT_W   = $clog2(FIFO_DEPTH + 1);

    localparam logic [c_CNT_W-1:0] c_DEPTH_CNT = c_CNT_W'(FIFO_DEPTH);
    localparam logic [X_SIZE-1:0]  c_DST_X     = X_SIZE'(DST_X);
    localparam logic [Y_SIZE-1:0]  c_DST_Y     = Y_SIZE'(DST_Y);

    localparam logic [1:0] c_MODE_INV  = 2'd0;
    localparam logic [1:0] c_MODE_PASS = 2'd1;
    localparam logic [1:0] c_MODE_THR  = 2'd2;

    localparam logic [PIX_W-1:0] c_PIX_ONES = {PIX_W{1'b1}};
    localparam logic [PIX_W-1:0] c_PIX_ZERO = {PIX_W{1'b0}};

    // ------------------------------------------------------------------------
    // Declarations
    // ------------------------------------------------------------------------
    logic                   w_accept;
    logic                   w_push;
    logic                   w_pop;
    logic [c_CNT_W-1:0]     w_occupancy;
    logic [TOTAL_WIDTH-1:0] w_flit_proc;

    logic                   r_stage_valid;
    logic [TOTAL_WIDTH-1:0] r_stage_data;

    logic [TOTAL_WIDTH-1:0] r_mem [FIFO_DEPTH];
    logic [c_PTR_W-1:0]     r_wr_ptr;
    logic [c_PTR_W-1:0]     r_rd_ptr;
    logic [c_CNT_W-1:0]     r_count;

    // The incoming routing coordinates are replaced, so they are never read.
    logic                   w_unused_hdr;
    assign w_unused_hdr = ^i_data[c_HDR_W-1:0];

    // ------------------------------------------------------------------------
    // Handshake
    // ------------------------------------------------------------------------
    // The stage register always drains into the FIFO on the following edge,
    // so a flit sitting in it already owns a FIFO slot. Counting it here is
    // what guarantees the unconditional stage-to-FIFO write never overflows.
    assign w_occupancy = r_count + c_CNT_W'(r_stage_valid);
    assign o_ready     = (w_occupancy < c_DEPTH_CNT);
    assign w_accept    = i_valid & o_ready;

    assign o_valid     = (r_count != '0);
    assign w_pop       = o_valid & i_ready;
    assign w_push      = r_stage_valid;

    // ------------------------------------------------------------------------
    // Header rewrite: send to the collector, keep the packet number
    // ------------------------------------------------------------------------
    assign w_flit_proc[X_SIZE-1:0]             = c_DST_X;
    assign w_flit_proc[c_HDR_W-1:X_SIZE]       = c_DST_Y;
    assign w_flit_proc[c_PIX_LSB-1:c_PCK_LSB]  = i_data[c_PIX_LSB-1:c_PCK_LSB];

    generate
        if (TOTAL_WIDTH > c_PIX_END) begin : g_spare
            logic w_unused_spare;
            assign w_unused_spare = ^i_data[TOTAL_WIDTH-1:c_PIX_END];
            assign w_flit_proc[TOTAL_WIDTH-1:c_PIX_END] = '0;
        end
    endgenerate

    // ------------------------------------------------------------------------
    // Per-lane pixel operation. Mode and parameter are used combinationally
    // at accept time and the result is registered, so later changes to
    // i_mode / i_param cannot affect a flit already in flight.
    // ------------------------------------------------------------------------
    generate
        for (genvar k = 0; k < ITER; k++) begin : g_lane
            logic [PIX_W-1:0] w_pix;
            logic [PIX_W:0]   w_sum;
            logic [PIX_W-1:0] w_res;

            assign w_pix = i_data[c_PIX_LSB + k*PIX_W +: PIX_W];
            // One extra bit catches the carry so the add clamps instead of
            // wrapping.
            assign w_sum = {1'b0, w_pix} + {1'b0, i_param};

            always_comb begin
                w_res = w_pix;
                case (i_mode)
                    c_MODE_INV:  w_res = ~w_pix;
                    c_MODE_PASS: w_res = w_pix;
                    c_MODE_THR:  w_res = (w_pix >= i_param) ? c_PIX_ONES
                                                            : c_PIX_ZERO;
                    default:     w_res = w_sum[PIX_W] ? c_PIX_ONES
                                                      : w_sum[PIX_W-1:0];
                endcase
            end

            assign w_flit_proc[c_PIX_LSB + k*PIX_W +: PIX_W] = w_res;
        end
    endgenerate

    // ------------------------------------------------------------------------
    // Stage 1: processed flit register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_stage_valid <= 1'b0;
        end else begin
            r_stage_valid <= w_accept;
        end
    end

    // Data is qualified by r_stage_valid, so it needs no reset.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_stage_data <= w_flit_proc;
        end
    end

    // ------------------------------------------------------------------------
    // Stage 2: first-word-fall-through FIFO
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= r_stage_data;
        end
    end

    // Pointers are exactly log2(depth) bits and wrap on their own; fullness
    // is tracked by the separate count, which spans 0..FIFO_DEPTH.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_CNT_W'(1);
                2'b01:   r_count <= r_count - c_CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Head is gated so the output reads 0 whenever nothing is valid
    // (including straight after reset, when the array is uninitialised).
    assign o_data = o_valid ? r_mem[r_rd_ptr] : '0;

    // ------------------------------------------------------------------------
    // Optional traffic statistics
    // ------------------------------------------------------------------------
`ifdef PIXEL_NODE_STATS_EN
    logic [31:0] r_rx_count;
    logic [31:0] r_tx_count;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rx_count <= '0;
            r_tx_count <= '0;
        end else begin
            if (w_accept) begin
                r_rx_count <= r_rx_count + 32'd1;
            end
            if (w_pop) begin
                r_tx_count <= r_tx_count + 32'd1;
            end
        end
    end

    assign o_rx_count = r_rx_count;
    assign o_tx_count = r_tx_count;
`else
    assign o_rx_count = 32'd0;
    assign o_tx_count = 32'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_pixel_proc_node.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_pixel_proc_node
// Purpose  : Self-checking bench for pixel_proc_node. A queue-based model
//            tracks every accepted flit (with the edge at which it becomes
//            visible) and predicts o_ready / o_valid / o_data / counters each
//            cycle. Directed table vectors, backpressure, full-FIFO and
//            mid-stream reset sequences are followed by random traffic.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pixel_proc_node;

    localparam int TW = 48;
    localparam int NL = 4;
    localparam int FD = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic [TW-1:0] i_data;
    logic          i_valid;
    logic          o_ready;
    logic [TW-1:0] o_data;
    logic          o_valid;
    logic          i_ready;
    logic [1:0]    i_mode;
    logic [7:0]    i_param;
    logic [31:0]   o_rx_count;
    logic [31:0]   o_tx_count;

    always #5 clk = ~clk;

    pixel_proc_node dut (
        .clk        (clk),
        .rst        (rst),
        .i_data     (i_data),
        .i_valid    (i_valid),
        .o_ready    (o_ready),
        .o_data     (o_data),
        .o_valid    (o_valid),
        .i_ready    (i_ready),
        .i_mode     (i_mode),
        .i_param    (i_param),
        .o_rx_count (o_rx_count),
        .o_tx_count (o_tx_count)
    );

    // ------------------------------------------------------------------------
    // Reference model state
    // ------------------------------------------------------------------------
    typedef struct {
        logic [TW-1:0] flit;
        int            vis;    // first edge index after which it is at the output
    } entry_t;

    entry_t q[$];
    int     edge_n;
    int     m_rx;
    int     m_tx;
    int     checks;
    int     failures;
    bit     d_acc;
    bit     d_pop;

    function automatic logic [TW-1:0] mk(input logic [7:0] p0, input logic [7:0] p1,
                                          input logic [7:0] p2, input logic [7:0] p3,
                                          input logic [7:0] pck, input logic [3:0] x,
                                          input logic [3:0] y);
        return {p3, p2, p1, p0, pck, y, x};
    endfunction

    // Expected output flit from plain arithmetic on each pixel value.
    function automatic logic [TW-1:0] model_flit(input logic [TW-1:0] d,
                                                  input logic [1:0] md,
                                                  input logic [7:0] prm);
        logic [TW-1:0] r;
        int p;
        int o;
        int t;
        r       = '0;          // collector is node (0,0)
        r[15:8] = d[15:8];
        t       = prm;
        for (int k = 0; k < NL; k++) begin
            p = d[16 + 8*k +: 8];
            case (md)
                2'd0:    o = 255 - p;
                2'd1:    o = p;
                2'd2:    o = (p >= t) ? 255 : 0;
                default: o = (p + t > 255) ? 255 : p + t;
            endcase
            r[16 + 8*k +: 8] = o[7:0];
        end
        return r;
    endfunction

    function automatic bit m_ready();
        return q.size() < FD;
    endfunction

    function automatic bit m_valid();
        return (q.size() > 0) && (q[0].vis <= edge_n);
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic compare_all();
        logic [TW-1:0] exp_data;
        exp_data = m_valid() ? q[0].flit : '0;
        check("o_ready", o_ready, m_ready());
        check("o_valid", o_valid, m_valid());
        check("o_data", o_data, exp_data);
`ifdef PIXEL_NODE_STATS_EN
        check("rx_count", o_rx_count, m_rx);
        check("tx_count", o_tx_count, m_tx);
`else
        check("rx_count", o_rx_count, 0);
        check("tx_count", o_tx_count, 0);
`endif
    endtask

    // One clock: drive inputs, predict, advance the model on the edge,
    // then compare everything on the falling edge.
    task automatic cycle(input bit v, input bit r, input logic [1:0] md,
                         input logic [7:0] prm, input logic [TW-1:0] d,
                         output bit acc, output bit pop);
        entry_t e;
        i_valid = v;
        i_ready = r;
        i_mode  = md;
        i_param = prm;
        i_data  = d;
        acc = !rst && v && m_ready();
        pop = !rst && r && m_valid();
        @(posedge clk);
        edge_n++;
        if (rst) begin
            q.delete();
            m_rx = 0;
            m_tx = 0;
        end else begin
            if (pop) begin
                void'(q.pop_front());
                m_tx++;
            end
            if (acc) begin
                e.flit = model_flit(d, md, prm);
                e.vis  = edge_n + 1;
                q.push_back(e);
                m_rx++;
            end
        end
        @(negedge clk);
        compare_all();
    endtask

    task automatic idle(input bit r);
        cycle(1'b0, r, 2'd0, 8'h00, '0, d_acc, d_pop);
    endtask

    typedef struct {
        logic [1:0]    md;
        logic [7:0]    prm;
        logic [TW-1:0] din;
        logic [TW-1:0] exp;
    } vec_t;

    vec_t tbl[7];

    initial begin
        bit            a;
        bit            p;
        int            nxt;
        int            na;
        int            np;
        logic [7:0]    head;
        int            popped[$];
        logic [TW-1:0] rd;
        logic [7:0]    prm;

        checks = 0; failures = 0; edge_n = 0; m_rx = 0; m_tx = 0;
        rst = 1'b1; i_valid = 1'b0; i_ready = 1'b0;
        i_mode = 2'd0; i_param = 8'h00; i_data = '0;

        tbl[0] = '{2'd0, 8'h00, mk(8'h00, 8'h7F, 8'h80, 8'hFF, 8'h5A, 4'd3, 4'd2),
                                mk(8'hFF, 8'h80, 8'h7F, 8'h00, 8'h5A, 4'd0, 4'd0)};
        tbl[1] = '{2'd3, 8'h30, mk(8'h10, 8'hD0, 8'hFF, 8'hCF, 8'h01, 4'd1, 4'd1),
                                mk(8'h40, 8'hFF, 8'hFF, 8'hFF, 8'h01, 4'd0, 4'd0)};
        tbl[2] = '{2'd2, 8'h80, mk(8'h7F, 8'h80, 8'h00, 8'hC0, 8'h02, 4'd7, 4'd9),
                                mk(8'h00, 8'hFF, 8'h00, 8'hFF, 8'h02, 4'd0, 4'd0)};
        tbl[3] = '{2'd1, 8'hEE, mk(8'h12, 8'h34, 8'h56, 8'h78, 8'hA5, 4'hF, 4'hF),
                                mk(8'h12, 8'h34, 8'h56, 8'h78, 8'hA5, 4'd0, 4'd0)};
        tbl[4] = '{2'd3, 8'h00, mk(8'hFF, 8'h00, 8'h01, 8'h80, 8'hFF, 4'd2, 4'd5),
                                mk(8'hFF, 8'h00, 8'h01, 8'h80, 8'hFF, 4'd0, 4'd0)};
        tbl[5] = '{2'd2, 8'h00, mk(8'h00, 8'h01, 8'h7F, 8'hFF, 8'h00, 4'd4, 4'd4),
                                mk(8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h00, 4'd0, 4'd0)};
        tbl[6] = '{2'd3, 8'hFF, mk(8'h00, 8'h01, 8'h80, 8'hFF, 8'h33, 4'd8, 4'd1),
                                mk(8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h33, 4'd0, 4'd0)};

        // ---- reset and idle ----
        idle(1'b0);
        idle(1'b0);
        rst = 1'b0;
        check("reset_o_valid", o_valid, 0);
        check("reset_o_ready", o_ready, 1);
        check("reset_o_data", o_data, 0);

        // ---- directed vectors: two edges of latency, mode sampled at accept ----
        for (int i = 0; i < 7; i++) begin
            cycle(1'b1, 1'b0, tbl[i].md, tbl[i].prm, tbl[i].din, a, p);
            check($sformatf("vec%0d_lat_early", i), o_valid, 0);
            cycle(1'b0, 1'b0, tbl[i].md ^ 2'b11, ~tbl[i].prm, '0, a, p);
            check($sformatf("vec%0d_valid", i), o_valid, 1);
            check($sformatf("vec%0d_data", i), o_data, tbl[i].exp);
            idle(1'b1);
            check($sformatf("vec%0d_drained", i), o_valid, 0);
        end

        // ---- backpressure: only FD flits fit, the rest follow in order ----
        nxt = 0;
        for (int c = 0; c < 10; c++) begin
            cycle(1'b1, 1'b0, 2'd1, 8'h00, mk(8'h11, 8'h22, 8'h33, 8'h44, 8'(nxt), 4'd6, 4'd6), a, p);
            if (a) nxt++;
        end
        check("bp_accepted", nxt, 8);
        check("bp_ready_low", o_ready, 0);
        for (int c = 0; c < 40 && popped.size() < 10; c++) begin
            head = o_data[15:8];
            cycle(nxt < 10, 1'b1, 2'd1, 8'h00,
                  mk(8'h11, 8'h22, 8'h33, 8'h44, 8'(nxt), 4'd6, 4'd6), a, p);
            if (a) nxt++;
            if (p) popped.push_back(head);
        end
        check("bp_popped_total", popped.size(), 10);
        for (int i = 0; i < popped.size(); i++)
            check($sformatf("bp_order%0d", i), popped[i], i);

        // ---- full FIFO with simultaneous push and pop ----
        for (int c = 0; c < 12 && q.size() < FD; c++)
            cycle(1'b1, 1'b0, 2'd0, 8'h00, mk(8'hA0, 8'hB0, 8'hC0, 8'hD0, 8'(c), 4'd1, 4'd2), a, p);
        check("full_ready_low", o_ready, 0);
        na = 0; np = 0;
        for (int c = 0; c < 20; c++) begin
            cycle(1'b1, 1'b1, 2'd3, 8'h40, mk(8'(c), 8'hF0, 8'h3F, 8'hC0, 8'(100 + c), 4'd1, 4'd2), a, p);
            na += int'(a);
            np += int'(p);
        end
        check("full_pops", np, 20);
        check("full_accepts", na, 19);
        for (int c = 0; c < 20 && q.size() > 0; c++) idle(1'b1);
        check("full_drained", o_valid, 0);

        // ---- reset mid-stream with 5 flits buffered ----
        for (int c = 0; c < 5; c++)
            cycle(1'b1, 1'b0, 2'd0, 8'h00, mk(8'h01, 8'h02, 8'h03, 8'h04, 8'(c), 4'd0, 4'd1), a, p);
        idle(1'b0);
        check("mid_buffered_valid", o_valid, 1);
        rst = 1'b1;
        cycle(1'b1, 1'b1, 2'd0, 8'h00, mk(8'h09, 8'h09, 8'h09, 8'h09, 8'h09, 4'd0, 4'd0), a, p);
        check("mid_rst_valid", o_valid, 0);
        check("mid_rst_ready", o_ready, 1);
        check("mid_rst_rx", o_rx_count, 0);
        check("mid_rst_tx", o_tx_count, 0);
        rst = 1'b0;
        idle(1'b1);
        check("mid_after_valid", o_valid, 0);

        // ---- random traffic against the model ----
        for (int c = 0; c < 600; c++) begin
            rd  = {16'($urandom), $urandom};
            prm = 8'($urandom);
            if ($urandom_range(0, 7) == 0) prm = 8'hFF;
            if ($urandom_range(0, 7) == 0) prm = 8'h00;
            cycle($urandom_range(0, 3) != 0, (c % 64) < 40 ? ($urandom_range(0, 2) != 0) : 1'b0,
                  2'($urandom), prm, rd, a, p);
        end
        for (int c = 0; c < 40 && q.size() > 0; c++) idle(1'b1);
        check("final_drained", o_valid, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
